uart_file_xfer_ctrl: RTL and testbench

//  Hardware host for the iob_uart register bus; performs the host-side file-transfer protocol in RTL.

---
 rtl/uart_file_xfer_ctrl_pkg.sv | 30 +++
 rtl/uart_file_xfer_ctrl_if.sv | 27 ++
 rtl/uart_file_xfer_ctrl_byte_io.sv | 80 ++++++++
 rtl/uart_file_xfer_ctrl.sv | 141 ++++++++++++++
 tb/tb_uart_file_xfer_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_file_xfer_ctrl_pkg.sv
// Shared constants for the UART file-transfer host: command bytes,
// iob_uart register map, FSM state types and a byte-extract helper.
package uart_file_xfer_ctrl_pkg;

   localparam logic [7:0] CMD_SEND = 8'd2;
   localparam logic [7:0] CMD_RECV = 8'd3;
   localparam logic [7:0] CMD_END  = 8'd4;

   localparam logic [2:0] REG_WRITE_WAIT = 3'd1;
   localparam logic [2:0] REG_DIV        = 3'd2;
   localparam logic [2:0] REG_DATA       = 3'd3;
   localparam logic [2:0] REG_SOFT_RESET = 3'd4;
   localparam logic [2:0] REG_READ_VALID = 3'd5;
   localparam logic [2:0] REG_RXEN       = 3'd6;

   typedef enum logic [1:0] {OP_WRITE, OP_GETCHAR, OP_PUTCHAR} io_op_t;

   typedef enum logic [1:0] {BIO_IDLE, BIO_RD1, BIO_RD2, BIO_GAP} bio_state_t;

   typedef enum logic [3:0] {
      ST_IDLE, ST_INIT, ST_CMD_GET, ST_DISPATCH, ST_SND_HDR,
      ST_SND_DATA, ST_RCV_HDR, ST_RCV_DATA, ST_DONE
   } xfer_state_t;

   // Byte i of a little-endian word.
   function automatic logic [7:0] byte_of(logic [31:0] w, logic [1:0] i);
      return w[{i, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/uart_file_xfer_ctrl_if.sv
// iob_uart register bus plus the word-read / byte-write memory ports.
interface uart_file_xfer_ctrl_if #(parameter int MEM_ADDR_W = 20);
   logic                  uart_sel;
   logic [2:0]            uart_addr;
   logic                  uart_wr;
   logic                  uart_rd;
   logic [31:0]           uart_di;
   logic [31:0]           uart_do;
   logic                  mem_ren;
   logic [MEM_ADDR_W-1:0] mem_raddr;
   logic [31:0]           mem_rdata;
   logic                  mem_wen;
   logic [MEM_ADDR_W-1:0] mem_waddr;
   logic [7:0]            mem_wdata;

   modport master (
      output uart_sel, uart_addr, uart_wr, uart_rd, uart_di,
      output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
      input  uart_do, mem_rdata
   );

   modport slave (
      input  uart_sel, uart_addr, uart_wr, uart_rd, uart_di,
      input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
      output uart_do, mem_rdata
   );
endinterface

// File: rtl/uart_file_xfer_ctrl_byte_io.sv
// iob_uart bus sequencer: single-cycle register writes, GETCHAR and PUTCHAR.
// rdy is high whenever a new op can be taken; a write is retired on
// acceptance so consecutive writes reach the bus on consecutive cycles.
module uart_file_xfer_ctrl_byte_io
   import uart_file_xfer_ctrl_pkg::*;
#(
   parameter int unsigned POLL_GAP = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  io_op_t      op,
   input  logic [2:0]  wr_addr,
   input  logic [31:0] wr_data,
   output logic        rdy,
   output logic [7:0]  rbyte,
   output logic        sel,
   output logic        wr,
   output logic        rd,
   output logic [2:0]  addr,
   output logic [31:0] di,
   input  logic [31:0] dout
);
   bio_state_t  st;
   logic        get_op;
   logic        data_ph;
   logic [7:0]  tx_byte;
   logic [15:0] gap_cnt;

   assign rdy = (st == BIO_IDLE);

   // Two-cycle reads; status polls repeat until the ready condition holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st <= BIO_IDLE; sel <= 1'b0; wr <= 1'b0; rd <= 1'b0;
         addr <= '0; di <= '0; rbyte <= '0;
         get_op <= 1'b0; data_ph <= 1'b0; tx_byte <= '0; gap_cnt <= '0;
      end else begin
         case (st)
            BIO_IDLE: begin
               sel <= 1'b0; wr <= 1'b0; rd <= 1'b0;
               if (req) begin
                  if (op == OP_WRITE) begin
                     sel <= 1'b1; wr <= 1'b1; addr <= wr_addr; di <= wr_data;
                  end else begin
                     get_op  <= (op == OP_GETCHAR);
                     tx_byte <= wr_data[7:0];
                     data_ph <= 1'b0;
                     sel <= 1'b1; rd <= 1'b1;
                     addr <= (op == OP_GETCHAR) ? REG_READ_VALID : REG_WRITE_WAIT;
                     st <= BIO_RD1;
                  end
               end
            end
            BIO_RD1: st <= BIO_RD2;
            BIO_RD2: begin
               st <= BIO_RD1;
               if (data_ph) begin
                  rbyte <= dout[7:0]; sel <= 1'b0; rd <= 1'b0; st <= BIO_IDLE;
               end else if (get_op && dout != '0) begin
                  addr <= REG_DATA; data_ph <= 1'b1;
               end else if (!get_op && dout == '0) begin
                  rd <= 1'b0; wr <= 1'b1; addr <= REG_DATA; di <= {24'd0, tx_byte};
                  st <= BIO_IDLE;
               end else if (POLL_GAP != 0) begin
                  sel <= 1'b0; rd <= 1'b0; gap_cnt <= 16'(POLL_GAP); st <= BIO_GAP;
               end
            end
            BIO_GAP: begin
               if (gap_cnt == 16'd1) begin
                  sel <= 1'b1; rd <= 1'b1; st <= BIO_RD1;
               end else begin
                  gap_cnt <= gap_cnt - 16'd1;
               end
            end
            default: st <= BIO_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/uart_file_xfer_ctrl.sv
// Host-side UART file-transfer controller: inits the UART, reads command
// bytes, streams memory out (cmd 2), stores an incoming file (cmd 3),
// echoes other bytes as console chars and stops on cmd 4.
module uart_file_xfer_ctrl
   import uart_file_xfer_ctrl_pkg::*;
#(
   parameter int          UART_DIV   = 868,
   parameter int          MEM_ADDR_W = 20,
   parameter int unsigned POLL_GAP   = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [31:0]                 tx_size,
   uart_file_xfer_ctrl_if.master       bus,
   output logic                        char_valid,
   output logic [7:0]                  char_data,
   output logic [31:0]                 rx_size,
   output logic                        busy,
   output logic                        done
);
   xfer_state_t           st;
   logic                  req, pending, rdy;
   io_op_t                op;
   logic [2:0]            io_addr;
   logic [31:0]           io_data;
   logic [7:0]            rbyte, cmd;
   logic [31:0]           cnt, tx_len, word, rx_shift;
   logic [1:0]            bidx, ph;
   logic                  mem_ren, mem_wen;
   logic [MEM_ADDR_W-1:0] mem_raddr, mem_waddr;
   logic [7:0]            mem_wdata;
   logic                  acc, fin, issue;

   assign acc   = req & rdy;
   assign fin   = pending & rdy;
   assign issue = ~req & ~pending;

   assign bus.mem_ren   = mem_ren;
   assign bus.mem_raddr = mem_raddr;
   assign bus.mem_wen   = mem_wen;
   assign bus.mem_waddr = mem_waddr;
   assign bus.mem_wdata = mem_wdata;

   uart_file_xfer_ctrl_byte_io #(.POLL_GAP(POLL_GAP)) u_io (
      .clk(clk), .rst(rst), .req(req), .op(op), .wr_addr(io_addr), .wr_data(io_data),
      .rdy(rdy), .rbyte(rbyte),
      .sel(bus.uart_sel), .wr(bus.uart_wr), .rd(bus.uart_rd),
      .addr(bus.uart_addr), .di(bus.uart_di), .dout(bus.uart_do)
   );

   // Protocol FSM: issues byte ops, owns counters, memory ports and status.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st <= ST_IDLE; req <= 1'b0; pending <= 1'b0; op <= OP_WRITE;
         io_addr <= '0; io_data <= '0; cmd <= '0; cnt <= '0; tx_len <= '0;
         word <= '0; rx_shift <= '0; bidx <= '0; ph <= '0;
         mem_ren <= 1'b0; mem_raddr <= '0; mem_wen <= 1'b0; mem_waddr <= '0; mem_wdata <= '0;
         char_valid <= 1'b0; char_data <= '0; rx_size <= '0; busy <= 1'b0; done <= 1'b0;
      end else begin
         char_valid <= 1'b0; mem_ren <= 1'b0; mem_wen <= 1'b0;
         if (acc) begin req <= 1'b0; pending <= (op != OP_WRITE); end
         if (fin) pending <= 1'b0;
         case (st)
            ST_IDLE: if (start) begin
               busy <= 1'b1; req <= 1'b1; op <= OP_WRITE;
               io_addr <= REG_SOFT_RESET; io_data <= 32'd1; cnt <= '0; st <= ST_INIT;
            end
            ST_INIT: if (acc) begin
               cnt <= cnt + 32'd1; req <= 1'b1;
               case (cnt[1:0])
                  2'd0:    begin io_addr <= REG_SOFT_RESET; io_data <= '0; end
                  2'd1:    begin io_addr <= REG_DIV; io_data <= 32'(UART_DIV); end
                  2'd2:    begin io_addr <= REG_RXEN; io_data <= 32'd1; end
                  default: begin req <= 1'b0; st <= ST_CMD_GET; end
               endcase
            end
            ST_CMD_GET: begin
               if (issue) begin req <= 1'b1; op <= OP_GETCHAR; end
               if (fin) begin cmd <= rbyte; st <= ST_DISPATCH; end
            end
            ST_DISPATCH: begin
               case (cmd)
                  CMD_SEND: begin tx_len <= tx_size; bidx <= '0; st <= ST_SND_HDR; end
                  CMD_RECV: begin bidx <= '0; st <= ST_RCV_HDR; end
                  CMD_END:  begin busy <= 1'b0; done <= 1'b1; st <= ST_DONE; end
                  default:  begin char_valid <= 1'b1; char_data <= cmd; st <= ST_CMD_GET; end
               endcase
            end
            ST_SND_HDR: begin
               if (issue) begin
                  req <= 1'b1; op <= OP_PUTCHAR; io_data <= {24'd0, byte_of(tx_len, bidx)};
               end
               if (fin) begin
                  bidx <= bidx + 2'd1; ph <= '0; cnt <= '0;
                  if (bidx == 2'd3) st <= (tx_len[31:2] == '0) ? ST_CMD_GET : ST_SND_DATA;
               end
            end
            ST_SND_DATA: begin
               case (ph)
                  2'd0: begin mem_ren <= 1'b1; mem_raddr <= cnt[MEM_ADDR_W-1:0]; ph <= 2'd1; end
                  2'd1: ph <= 2'd2;
                  2'd2: begin word <= bus.mem_rdata; ph <= 2'd3; end
                  default: begin
                     if (issue) begin
                        req <= 1'b1; op <= OP_PUTCHAR; io_data <= {24'd0, byte_of(word, bidx)};
                     end
                     if (fin) begin
                        bidx <= bidx + 2'd1;
                        if (bidx == 2'd3) begin
                           ph <= '0; cnt <= cnt + 32'd1;
                           if (cnt + 32'd1 == {2'b00, tx_len[31:2]}) st <= ST_CMD_GET;
                        end
                     end
                  end
               endcase
            end
            ST_RCV_HDR: begin
               if (issue) begin req <= 1'b1; op <= OP_GETCHAR; end
               if (fin) begin
                  rx_shift <= {rbyte, rx_shift[31:8]}; bidx <= bidx + 2'd1;
                  if (bidx == 2'd3) begin
                     rx_size <= {rbyte, rx_shift[31:8]}; cnt <= '0;
                     st <= ({rbyte, rx_shift[31:8]} == '0) ? ST_CMD_GET : ST_RCV_DATA;
                  end
               end
            end
            ST_RCV_DATA: begin
               if (issue) begin req <= 1'b1; op <= OP_GETCHAR; end
               if (fin) begin
                  mem_wen <= 1'b1; mem_waddr <= cnt[MEM_ADDR_W-1:0]; mem_wdata <= rbyte;
                  cnt <= cnt + 32'd1;
                  if (cnt + 32'd1 == rx_size) st <= ST_CMD_GET;
               end
            end
            ST_DONE: ;
            default: st <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_file_xfer_ctrl.sv
// Bench for uart_file_xfer_ctrl: a behavioural iob_uart slave and word memory,
// a transaction-level model of the file protocol, and one monitor that
// checks every bus write, console char and memory write against the model.
module tb_uart_file_xfer_ctrl;
   import uart_file_xfer_ctrl_pkg::*;
   localparam int AW = 20;

   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [31:0] tx_size = '0;
   logic        char_valid, busy, done;
   logic [7:0]  char_data;
   logic [31:0] rx_size;

   uart_file_xfer_ctrl_if #(.MEM_ADDR_W(AW)) bus();

   uart_file_xfer_ctrl #(.UART_DIV(868), .MEM_ADDR_W(AW), .POLL_GAP(0)) dut (
      .clk(clk), .rst(rst), .start(start), .tx_size(tx_size), .bus(bus),
      .char_valid(char_valid), .char_data(char_data), .rx_size(rx_size),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, cyc = 0;
   int n_bus = 0, n_mem = 0, n_rv = 0, ww_cnt = 0, rd_ph = 0, last_wr_cyc = 0;
   logic [2:0]  rd_addr = '0;
   logic [31:0] mem [0:15];
   logic [7:0]  rxq[$], exp_tx[$], exp_char[$], txlog[$];
   logic [39:0] exp_mw[$];
   logic [34:0] exp_wr[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic unexp(input string nm, input logic [31:0] v);
      n_chk++; n_fail++;
      $display("FAIL %s: actual event %0h required none (cycle %0d)", nm, v, cyc);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // UART slave, memory and output monitor; sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         rd_ph <= 0;
      end else begin
         if (bus.uart_sel) n_bus <= n_bus + 1;
         if (bus.mem_ren || bus.mem_wen) n_mem <= n_mem + 1;
         if (bus.uart_sel) chk("wr_rd_exclusive", 32'(bus.uart_wr & bus.uart_rd), 0);
         chk("ren_wen_exclusive", 32'(bus.mem_ren & bus.mem_wen), 0);
         if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_raddr[3:0]];
         // reads: value presented from the first cycle, side effect once
         if (bus.uart_sel && bus.uart_rd) begin
            if (rd_ph == 0) begin
               rd_ph <= 1; rd_addr <= bus.uart_addr;
               case (bus.uart_addr)
                  REG_READ_VALID: begin bus.uart_do <= (rxq.size() != 0) ? 32'd1 : 32'd0; n_rv <= n_rv + 1; end
                  REG_WRITE_WAIT: begin bus.uart_do <= (ww_cnt % 3 == 1) ? 32'd1 : 32'd0; ww_cnt <= ww_cnt + 1; end
                  REG_DATA: if (rxq.size() != 0) bus.uart_do <= {24'd0, rxq.pop_front()};
                            else unexp("data_read_empty", 32'(bus.uart_addr));
                  default: unexp("read_bad_addr", 32'(bus.uart_addr));
               endcase
            end else begin
               chk("read_addr_stable", 32'(bus.uart_addr), 32'(rd_addr));
               rd_ph <= 0;
            end
         end else if (rd_ph != 0) begin
            chk("read_two_cycles", 32'(rd_ph), 0);
            rd_ph <= 0;
         end
         if (bus.uart_sel && bus.uart_wr) begin
            if (exp_wr.size() != 0) begin
               chk("init_wr_addr", 32'(bus.uart_addr), 32'(exp_wr[0][34:32]));
               chk("init_wr_data", bus.uart_di, exp_wr[0][31:0]);
               if (exp_wr.size() < 4) chk("init_back_to_back", 32'(cyc), 32'(last_wr_cyc + 1));
               last_wr_cyc <= cyc;
               void'(exp_wr.pop_front());
            end else begin
               chk("tx_addr", 32'(bus.uart_addr), 32'(REG_DATA));
               txlog.push_back(bus.uart_di[7:0]);
               if (exp_tx.size() != 0) begin
                  chk("tx_byte", 32'(bus.uart_di[7:0]), 32'(exp_tx[0]));
                  void'(exp_tx.pop_front());
               end else unexp("tx_unexpected", bus.uart_di);
            end
         end
         if (char_valid) begin
            if (exp_char.size() != 0) begin
               chk("char_data", 32'(char_data), 32'(exp_char[0]));
               void'(exp_char.pop_front());
            end else unexp("char_unexpected", 32'(char_data));
         end
         if (bus.mem_wen) begin
            if (exp_mw.size() != 0) begin
               chk("mem_waddr", 32'(bus.mem_waddr), 32'(exp_mw[0][39:8]));
               chk("mem_wdata", 32'(bus.mem_wdata), 32'(exp_mw[0][7:0]));
               void'(exp_mw.pop_front());
            end else unexp("mem_wen_unexpected", 32'(bus.mem_waddr));
         end
      end
   end

   // Model: expected host behaviour for each command byte the far side sends.
   task automatic exp_init();
      exp_wr.push_back({REG_SOFT_RESET, 32'd1});
      exp_wr.push_back({REG_SOFT_RESET, 32'd0});
      exp_wr.push_back({REG_DIV, 32'd868});
      exp_wr.push_back({REG_RXEN, 32'd1});
   endtask

   task automatic model_char(input logic [7:0] c);
      rxq.push_back(c); exp_char.push_back(c);
   endtask

   task automatic model_send(input logic [31:0] sz);
      tx_size = sz;
      for (int b = 0; b < 4; b++) exp_tx.push_back(8'((sz >> (8 * b)) & 32'hFF));
      for (int w = 0; w < int'(sz / 4); w++)
         for (int b = 0; b < 4; b++) exp_tx.push_back(8'((mem[w] >> (8 * b)) & 32'hFF));
      rxq.push_back(CMD_SEND);
   endtask

   task automatic model_recv(input int n, input logic [7:0] first);
      rxq.push_back(CMD_RECV);
      for (int b = 0; b < 4; b++) rxq.push_back(8'((n >> (8 * b)) & 255));
      for (int i = 0; i < n; i++) begin
         rxq.push_back(first + 8'(i * 17));
         exp_mw.push_back({32'(i), first + 8'(i * 17)});
      end
   endtask

   task automatic wait_drain(input string nm, input int max);
      int i = 0;
      while ((exp_wr.size() + exp_tx.size() + exp_char.size() + exp_mw.size() + rxq.size()) != 0
             && i < max) begin
         @(negedge clk); i++;
      end
      chk({nm, "_completes"}, 32'(i < max), 1);
      repeat (6) @(negedge clk);
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   initial begin
      logic [7:0] lit [12];
      int nb;
      lit = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);   chk("rst_done", 32'(done), 0);
      chk("rst_sel", 32'(bus.uart_sel), 0);  chk("rst_rx_size", rx_size, 0);
      chk("rst_mem", 32'(bus.mem_ren | bus.mem_wen), 0);
      rst = 1'b0;

      // 1: init sequence then status polling
      exp_init();
      pulse_start();
      wait_drain("init", 100);
      chk("init_busy", 32'(busy), 1); chk("init_done", 32'(done), 0);
      chk("polling_seen", 32'(n_rv > 0), 1);

      // 2: console chars; a start while busy changes nothing
      nb = n_mem;
      pulse_start();
      model_char(8'h48); model_char(8'h69); model_char(8'h0A);
      wait_drain("chars", 500);
      chk("chars_no_mem", 32'(n_mem), 32'(nb));

      // 3: cmd 2 streams header and two words
      mem[0] = 32'h44332211; mem[1] = 32'h88776655;
      txlog.delete();
      model_send(32'd8);
      wait_drain("send8", 2000);
      chk("send8_len", 32'(txlog.size()), 12);
      for (int i = 0; i < 12 && i < txlog.size(); i++) chk("send8_literal", 32'(txlog[i]), 32'(lit[i]));

      // boundaries: low two size bits ignored, size below a word sends header only
      model_send(32'd6);
      wait_drain("send6", 2000);
      txlog.delete();
      model_send(32'd3);
      wait_drain("send3", 2000);
      chk("send3_header_only", 32'(txlog.size()), 4);

      // 4: cmd 3, empty file then five bytes AA..EE
      nb = n_mem;
      model_recv(0, 8'h00);
      wait_drain("recv0", 500);
      chk("recv0_size", rx_size, 0); chk("recv0_no_mem", 32'(n_mem), 32'(nb));
      model_recv(5, 8'hAA);
      wait_drain("recv5", 2000);
      chk("recv5_size", rx_size, 5);

      // 5: cmd 4 ends; bus stays idle and start is ignored
      rxq.push_back(CMD_END);
      for (int i = 0; i < 200 && !done; i++) @(negedge clk);
      chk("end_done", 32'(done), 1); chk("end_busy", 32'(busy), 0);
      nb = n_bus;
      repeat (10) @(negedge clk);
      pulse_start();
      repeat (20) @(negedge clk);
      chk("end_bus_idle", 32'(n_bus), 32'(nb));
      chk("end_done_sticky", 32'(done), 1); chk("end_busy_after_start", 32'(busy), 0);

      // 6: reset mid cmd-2 stream, then a full re-init
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      chk("rst_clears_done", 32'(done), 0);
      exp_init();
      pulse_start();
      wait_drain("reinit1", 100);
      for (int i = 0; i < 4; i++) mem[i] = 32'hA0B0C0D0 + 32'(i);
      model_recv(5, 8'h10);
      wait_drain("recv_pre", 2000);
      txlog.delete();
      model_send(32'd16);
      for (int i = 0; i < 2000 && txlog.size() < 8; i++) @(negedge clk);
      chk("stream_started", 32'(txlog.size() >= 8), 1);
      #2 rst = 1'b1;
      #1;
      chk("abort_sel", 32'(bus.uart_sel | bus.uart_wr | bus.uart_rd), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_mem", 32'(bus.mem_ren | bus.mem_wen), 0);
      chk("abort_rx_size", rx_size, 0);
      @(negedge clk);
      exp_tx.delete(); rxq.delete();
      @(negedge clk); rst = 1'b0;
      exp_init();
      pulse_start();
      wait_drain("reinit2", 100);
      chk("reinit_busy", 32'(busy), 1);
      rxq.push_back(CMD_END);
      for (int i = 0; i < 200 && !done; i++) @(negedge clk);
      chk("final_done", 32'(done), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
